// File: rtl/bsg_link_ddr_token_return_if.sv
// bsg_link_ddr_token_return_if: link beat, core handshake and credit-return signals; stats ports under BSG_LINK_TOKEN_STATS_EN
interface bsg_link_ddr_token_return_if #(parameter int width_p = 64);
  logic                 io_valid_i;
  logic [width_p/2-1:0] io_data_i;
  logic                 core_valid_o;
  logic [width_p-1:0]   core_data_o;
  logic                 core_yumi_i;
  logic                 token_clk_o;
  logic                 overflow_o;
`ifdef BSG_LINK_TOKEN_STATS_EN
  logic [7:0]           recv_words_o;
  logic [7:0]           tokens_sent_o;
  modport slave (
    input  io_valid_i, io_data_i, core_yumi_i,
    output core_valid_o, core_data_o, token_clk_o, overflow_o, recv_words_o, tokens_sent_o
  );
  modport master (
    output io_valid_i, io_data_i, core_yumi_i,
    input  core_valid_o, core_data_o, token_clk_o, overflow_o, recv_words_o, tokens_sent_o
  );
`else
  modport slave (
    input  io_valid_i, io_data_i, core_yumi_i,
    output core_valid_o, core_data_o, token_clk_o, overflow_o
  );
  modport master (
    output io_valid_i, io_data_i, core_yumi_i,
    input  core_valid_o, core_data_o, token_clk_o, overflow_o
  );
`endif
endinterface

// File: rtl/bsg_link_ddr_token_return.sv
// bsg_link_ddr_token_return: reassembles half-word link beats into a credit-sized FIFO and toggles token_clk_o per 2^lg_credit_decimation_p dequeues; optional counters under BSG_LINK_TOKEN_STATS_EN
module bsg_link_ddr_token_return #(
  parameter int width_p                = 64,
  parameter int fifo_els_p             = 16,
  parameter int lg_credit_decimation_p = 3
) (
  input logic clk,
  input logic rst,
  bsg_link_ddr_token_return_if.slave io
);
  localparam int lg_els_lp = $clog2(fifo_els_p);
  localparam int half_lp   = width_p / 2;
  logic                              phase_q, phase_d;
  logic [half_lp-1:0]                half_q, half_d;
  logic [width_p-1:0]                mem_q [fifo_els_p];
  logic [width_p-1:0]                mem_d [fifo_els_p];
  logic [lg_els_lp-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [lg_els_lp:0]                count_q, count_d;
  logic [lg_credit_decimation_p-1:0] dec_q, dec_d;
  logic                              token_q, token_d;
  logic                              overflow_q, overflow_d;
  logic                              word_done, full, deq, enq, wrap;
  assign word_done = io.io_valid_i & phase_q;
  assign full      = count_q == (lg_els_lp+1)'(fifo_els_p);
  assign deq       = io.core_yumi_i & (count_q != '0);
  // a full FIFO still accepts a word when the same cycle frees a slot
  assign enq       = word_done & (~full | deq);
  assign wrap      = deq & (&dec_q);
  always_comb begin
    phase_d    = io.io_valid_i ? ~phase_q : phase_q;
    half_d     = (io.io_valid_i & ~phase_q) ? io.io_data_i : half_q;
    mem_d      = mem_q;
    if (enq) mem_d[wptr_q] = {io.io_data_i, half_q};
    wptr_d     = wptr_q + lg_els_lp'(enq);
    rptr_d     = rptr_q + lg_els_lp'(deq);
    count_d    = count_q + (lg_els_lp+1)'(enq) - (lg_els_lp+1)'(deq);
    dec_d      = dec_q + lg_credit_decimation_p'(deq);
    token_d    = token_q ^ wrap;
    overflow_d = overflow_q | (word_done & ~enq);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      half_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dec_q      <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      half_q     <= half_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      dec_q      <= dec_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign io.core_valid_o = count_q != '0;
  assign io.core_data_o  = mem_q[rptr_q];
  assign io.token_clk_o  = token_q;
  assign io.overflow_o   = overflow_q;
`ifdef BSG_LINK_TOKEN_STATS_EN
  logic [7:0] recv_q, recv_d, toks_q, toks_d;
  always_comb begin
    recv_d = recv_q + 8'(enq);
    toks_d = toks_q + 8'(wrap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      recv_q <= '0;
      toks_q <= '0;
    end else begin
      recv_q <= recv_d;
      toks_q <= toks_d;
    end
  end
  assign io.recv_words_o  = recv_q;
  assign io.tokens_sent_o = toks_q;
`endif
endmodule

// File: tb/tb_bsg_link_ddr_token_return.sv
// tb_bsg_link_ddr_token_return: directed and random beats/yumis checked against a queue-based credit model
module tb_bsg_link_ddr_token_return;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bsg_link_ddr_token_return_if #(.width_p(64)) bus ();
  bsg_link_ddr_token_return #(.width_p(64), .fifo_els_p(16), .lg_credit_decimation_p(3)) dut (
    .clk(clk), .rst(rst), .io(bus)
  );
  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  bit          ph;
  logic [31:0] half;
  int          ndeq;
  int          recv;
  bit          ovf;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("core_valid", 64'(bus.core_valid_o), 64'(q.size() != 0));
    if (q.size() != 0) chk("core_data", bus.core_data_o, q[0]);
    chk("token_clk", 64'(bus.token_clk_o), 64'((ndeq >> 3) & 1));
    chk("overflow", 64'(bus.overflow_o), 64'(ovf));
`ifdef BSG_LINK_TOKEN_STATS_EN
    chk("recv_words", 64'(bus.recv_words_o), 64'(recv % 256));
    chk("tokens_sent", 64'(bus.tokens_sent_o), 64'((ndeq >> 3) % 256));
`endif
  endtask
  task automatic step(input bit v, input logic [31:0] d, input bit y);
    bus.io_valid_i = v;
    bus.io_data_i = d;
    bus.core_yumi_i = y;
    @(posedge clk);
    if (y && q.size() != 0) begin
      void'(q.pop_front());
      ndeq++;
    end
    if (v) begin
      if (ph) begin
        if (q.size() < 16) begin
          q.push_back({d, half});
          recv++;
        end else ovf = 1;
      end else half = d;
      ph = ~ph;
    end
    @(negedge clk);
    bus.io_valid_i = 1'b0;
    bus.core_yumi_i = 1'b0;
    check_all();
  endtask
  task automatic word(input logic [63:0] w, input bit y);
    step(1'b1, w[31:0], 1'b0);
    step(1'b1, w[63:32], y);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.io_valid_i = 1'b0;
    bus.core_yumi_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ph = 0; half = '0; ndeq = 0; recv = 0; ovf = 0;
    check_all();
  endtask
  initial begin
    bus.io_valid_i = 1'b0;
    bus.io_data_i = '0;
    bus.core_yumi_i = 1'b0;
    @(negedge clk);
    do_reset();
    step(1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'h22222222, 1'b0);
    chk("first_word", bus.core_data_o, 64'h2222222211111111);
    chk("first_valid", 64'(bus.core_valid_o), 64'd1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'hAAAA0001, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, 1'b0);
    step(1'b1, 32'hBBBB0002, 1'b0);
    chk("span_word", bus.core_data_o, 64'hBBBB0002AAAA0001);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) word({$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("token_before", 64'(bus.token_clk_o), 64'd0);
      step(1'b0, '0, 1'b1);
    end
    chk("token_up", 64'(bus.token_clk_o), 64'd1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    chk("token_down", 64'(bus.token_clk_o), 64'd0);
    chk("drained", 64'(bus.core_valid_o), 64'd0);
    step(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 17; i++) word({$urandom, $urandom}, 1'b0);
    chk("overflow_set", 64'(bus.overflow_o), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    chk("overflow_sticky", 64'(bus.overflow_o), 64'd1);
    chk("no_17th", 64'(bus.core_valid_o), 64'd0);
    do_reset();
    for (int i = 0; i < 16; i++) word({$urandom, $urandom}, 1'b0);
    word(64'hC0FFEE0017171717, 1'b1);
    chk("full_swap_ovf", 64'(bus.overflow_o), 64'd0);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
    chk("last_is_17th", bus.core_data_o, 64'hC0FFEE0017171717);
    step(1'b0, '0, 1'b1);
    chk("full_swap_empty", 64'(bus.core_valid_o), 64'd0);
    do_reset();
    for (int i = 0; i < 10; i++) word({$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    step(1'b1, $urandom, 1'b0);
    do_reset();
    chk("rst_valid", 64'(bus.core_valid_o), 64'd0);
    chk("rst_token", 64'(bus.token_clk_o), 64'd0);
    chk("rst_overflow", 64'(bus.overflow_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      word({$urandom, $urandom}, 1'b0);
      step(1'b0, '0, 1'b1);
    end
    chk("rst_one_toggle", 64'(bus.token_clk_o), 64'd1);
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_link_ddr_token_return.md
Name: bsg_link_ddr_token_return

Overview:
- Downstream counterpart of the DDR link upstream token-in path.
- Accepts half-word beats from the link, reassembles full core words and buffers them in a credit-sized FIFO.
- Presents words to the core with a valid/yumi handshake.
- Returns credits to the upstream sender by toggling a token clock once per 2^lg_credit_decimation_p core dequeues.
- Single-clock simplified form, used for formal and ILA refinement against the upstream credit counters.

Parameters:
- width_p, 64, core word width; must be even. Each link beat carries width_p/2 bits.
- fifo_els_p, 16, FIFO depth; power of 2. Equals the credits the upstream holds out of reset.
- lg_credit_decimation_p, 3, log2 of dequeues per token toggle; 2^lg_credit_decimation_p must divide fifo_els_p.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- io_valid_i  input  1  link beat valid.
- io_data_i  input  width_p/2  link beat data; low half first, then high half.
- core_valid_o  output  1  FIFO head valid.
- core_data_o  output  width_p  FIFO head word.
- core_yumi_i  input  1  core consumes head this cycle; legal only when core_valid_o=1.
- token_clk_o  output  1  credit-return toggle, registered.
- overflow_o  output  1  sticky error: a word arrived with the FIFO full and no dequeue.

Behaviour:
Reset values:
- core_valid_o=0, token_clk_o=0, overflow_o=0.
- Assembly phase=0, FIFO pointers/count=0, decimation counter=0.
- core_data_o is don't-care while core_valid_o=0.

Assembler (phase bit):
- phase=0 and io_valid_i=1: io_data_i captured into half_r; phase becomes 1.
- phase=1 and io_valid_i=1: word {io_data_i, half_r} enqueued; phase becomes 0.
- io_valid_i=0: phase and half_r hold. A word may span idle cycles.

FIFO:
- Storage is a register array; wptr/rptr are log2(fifo_els_p) bits and wrap naturally.
- count is log2(fifo_els_p)+1 bits.
- core_valid_o = (count != 0).
- core_data_o = mem[rptr], read combinationally.
- Latency: a word is visible on core_valid_o the cycle after its high half is accepted; no bypass.

Boundary conditions:
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance. This holds when full (slot freed and refilled) and when count=1.
- Enqueue when count=fifo_els_p with no yumi: word dropped, pointers unchanged, overflow_o set to 1 and held until rst.
- yumi while empty: ignored. No pointer or counter change, no token.

Token return:
- The decimation counter (lg_credit_decimation_p bits) increments on every accepted dequeue.
- When a dequeue makes it wrap from all-ones to 0, token_clk_o toggles on the next clock edge. One toggle equals 2^lg_credit_decimation_p credits returned.
- The upstream counts toggles on both edges. It therefore sees credits = toggles * 2^lg_credit_decimation_p, matching its finish counter with 3 LSBs zero at default.

Reset mid-operation:
- A partial half-word is discarded and FIFO contents are lost.
- A partial decimation count is discarded and token_clk_o returns to 0.
- The upstream must be reset together with this block.

Invariant:
- count + pending credits at upstream = fifo_els_p, whenever overflow_o=0 and the sender obeys credits.

Optional Feature:
BSG_LINK_TOKEN_STATS_EN
- Defined: adds outputs recv_words_o [7:0] and tokens_sent_o [7:0].
  - recv_words_o counts enqueued words (dropped words excluded).
  - tokens_sent_o counts token_clk_o toggles.
  - Both wrap modulo 256 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then beats 0x11111111, 0x22222222 on consecutive cycles -> next cycle core_valid_o=1, core_data_o=0x2222222211111111; token_clk_o=0.
- Low half beat, 3 idle cycles, high half beat -> single word enqueued; no extra enqueue during idle.
- Enqueue 16 words, then yumi 8 in a row -> token_clk_o toggles to 1 exactly one cycle after 8th yumi; yumi 8 more -> toggles back to 0; core_valid_o=0.
- Fill to 16, deliver 17th word with no yumi -> overflow_o=1 and sticky; dequeue all 16 -> data equals first 16 words in order, 17th absent.
- Full FIFO, 17th word completes same cycle as yumi -> count stays 16, overflow_o=0; the 17th word is read out last.
- Assert rst with count=5, phase=1, decimation counter=5 -> next cycle all outputs at reset values; after reset, 8 word/yumi pairs produce exactly one toggle.
